// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control unit: opcodes, FSM states,
// instruction classes and the datapath select/cause encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC,
        CL_ILLEGAL
    } instr_class_t;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Link-writing classes write PC+4 back to rd.
    function automatic logic is_link_class(instr_class_t c);
        return (c == CL_JAL) || (c == CL_JALR);
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_instr_class_decode.sv
// Combinational opcode -> instruction class decoder. Jump/upper-immediate
// opcodes are only recognised when EN_JUMP is non-zero; otherwise illegal.
module instr_class_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int EN_JUMP = 1
)(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    // Map the 7-bit major opcode onto a class; unknown opcodes are illegal.
    always_comb begin
        instr_class = CL_ILLEGAL;
        case (opcode)
            OPC_R:      instr_class = CL_R;
            OPC_I:      instr_class = CL_I;
            OPC_LOAD:   instr_class = CL_LOAD;
            OPC_STORE:  instr_class = CL_STORE;
            OPC_BRANCH: instr_class = CL_BRANCH;
            OPC_JAL:    if (EN_JUMP != 0) instr_class = CL_JAL;
            OPC_JALR:   if (EN_JUMP != 0) instr_class = CL_JALR;
            OPC_LUI:    if (EN_JUMP != 0) instr_class = CL_LUI;
            OPC_AUIPC:  if (EN_JUMP != 0) instr_class = CL_AUIPC;
            default:    instr_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// RV32 multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// stalling memory handshake, sticky traps (illegal opcode, memory timeout)
// and a retired-instruction counter.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter int EN_JUMP     = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t             state_reg, state_next;
    instr_class_t       class_reg, class_next;
    instr_class_t       decoded_class;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               trap_reg, trap_next;
    logic [1:0]         trap_cause_reg, trap_cause_next;
    logic [CNT_W-1:0]   instret_reg;
    logic               retire;
    logic               timeout_hit;

    logic               mem_read_comb, mem_write_comb, iord_comb, ir_write_comb;
    logic               pc_write_comb, pc_src_comb, alu_src_a_comb, reg_write_comb;
    logic [1:0]         alu_src_b_comb, alu_op_comb, mem_to_reg_comb;

    instr_class_decode #(
        .EN_JUMP     (EN_JUMP)
    ) u_decode (
        .opcode      (opcode),
        .instr_class (decoded_class)
    );

    // A late mem_ready on the final counted cycle still wins over the trap.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_MAX) && !mem_ready;

    // Next-state, trap capture, retirement and datapath controls (Moore except
    // the FETCH handshake and the branch-taken PC write).
    always_comb begin
        state_next      = state_reg;
        class_next      = class_reg;
        trap_next       = trap_reg;
        trap_cause_next = trap_cause_reg;
        retire          = 1'b0;
        mem_read_comb   = 1'b0;
        mem_write_comb  = 1'b0;
        iord_comb       = 1'b0;
        ir_write_comb   = 1'b0;
        pc_write_comb   = 1'b0;
        pc_src_comb     = 1'b0;
        alu_src_a_comb  = 1'b0;
        alu_src_b_comb  = SRC_B_RS2;
        alu_op_comb     = ALU_OP_ADD;
        reg_write_comb  = 1'b0;
        mem_to_reg_comb = WB_ALU;
        case (state_reg)
            ST_FETCH: begin
                mem_read_comb = 1'b1;
                if (mem_ready) begin
                    ir_write_comb = 1'b1;
                    pc_write_comb = 1'b1;
                    state_next    = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next      = ST_TRAP;
                    trap_next       = 1'b1;
                    trap_cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                // Branch target PC+imm is formed here while the class resolves.
                alu_src_a_comb = 1'b1;
                alu_src_b_comb = SRC_B_IMM;
                alu_op_comb    = ALU_OP_ADD;
                class_next     = decoded_class;
                if (decoded_class == CL_ILLEGAL) begin
                    state_next      = ST_TRAP;
                    trap_next       = 1'b1;
                    trap_cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_reg)
                    CL_R: begin
                        alu_op_comb = ALU_OP_RTYPE;
                        state_next  = ST_WB;
                    end
                    CL_I: begin
                        alu_op_comb    = ALU_OP_ITYPE;
                        alu_src_b_comb = SRC_B_IMM;
                        state_next     = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b_comb = SRC_B_IMM;
                        state_next     = ST_MEM;
                    end
                    CL_BRANCH: begin
                        alu_op_comb   = ALU_OP_BRANCH;
                        pc_write_comb = br_taken;
                        pc_src_comb   = 1'b1;
                        retire        = 1'b1;
                        state_next    = ST_FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        pc_write_comb = 1'b1;
                        pc_src_comb   = 1'b1;
                        state_next    = ST_WB;
                    end
                    CL_LUI, CL_AUIPC: begin
                        // LUI relies on the datapath zeroing rs1 for a plain imm.
                        alu_src_a_comb = (class_reg == CL_AUIPC);
                        alu_src_b_comb = SRC_B_IMM;
                        state_next     = ST_WB;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord_comb      = 1'b1;
                mem_read_comb  = (class_reg == CL_LOAD);
                mem_write_comb = (class_reg == CL_STORE);
                if (mem_ready) begin
                    if (class_reg == CL_LOAD) begin
                        state_next = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_next      = ST_TRAP;
                    trap_next       = 1'b1;
                    trap_cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write_comb = 1'b1;
                if (class_reg == CL_LOAD) begin
                    mem_to_reg_comb = WB_MEM;
                end else if (is_link_class(class_reg)) begin
                    mem_to_reg_comb = WB_PC4;
                end
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Wait counter: counts stalled cycles while staying in FETCH/MEM, clears otherwise.
    always_comb begin
        wait_cnt_next = '0;
        if ((MEM_TIMEOUT != 0) && ((state_reg == ST_FETCH) || (state_reg == ST_MEM))
                && (state_next == state_reg) && !mem_ready) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    // State, class, timeout, trap and retirement registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_FETCH;
            class_reg      <= CL_ILLEGAL;
            wait_cnt_reg   <= '0;
            trap_reg       <= 1'b0;
            trap_cause_reg <= CAUSE_NONE;
            instret_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            class_reg      <= class_next;
            wait_cnt_reg   <= wait_cnt_next;
            trap_reg       <= trap_next;
            trap_cause_reg <= trap_cause_next;
            instret_reg    <= instret_reg + {{(CNT_W-1){1'b0}}, retire};
        end
    end

    // Every output is held at zero while reset is asserted.
    assign mem_read   = rst_n & mem_read_comb;
    assign mem_write  = rst_n & mem_write_comb;
    assign iord       = rst_n & iord_comb;
    assign ir_write   = rst_n & ir_write_comb;
    assign pc_write   = rst_n & pc_write_comb;
    assign pc_src     = rst_n & pc_src_comb;
    assign alu_src_a  = rst_n & alu_src_a_comb;
    assign alu_src_b  = rst_n ? alu_src_b_comb  : 2'b00;
    assign alu_op     = rst_n ? alu_op_comb     : 2'b00;
    assign reg_write  = rst_n & reg_write_comb;
    assign mem_to_reg = rst_n ? mem_to_reg_comb : 2'b00;
    assign trap       = rst_n & trap_reg;
    assign trap_cause = rst_n ? trap_cause_reg  : 2'b00;
    assign instret    = rst_n ? instret_reg     : '0;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl. The driver applies directed
// per-cycle inputs and queues the hand-computed output vector for that cycle;
// an independent monitor pops and compares on the falling edge.
module tb_riscv_multicycle_ctrl;

    localparam int CNT_W = 4;

    // Output vector layout:
    // {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
    //  alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg[1:0], trap, trap_cause[1:0]}
    localparam logic [16:0] V_ZERO       = 17'h00000;
    localparam logic [16:0] V_FETCH_WAIT = 17'h10000;
    localparam logic [16:0] V_FETCH_RDY  = 17'h13000;
    localparam logic [16:0] V_DECODE     = 17'h00600;
    localparam logic [16:0] V_EX_R       = 17'h00080;
    localparam logic [16:0] V_EX_I       = 17'h002C0;
    localparam logic [16:0] V_EX_LS      = 17'h00200;
    localparam logic [16:0] V_EX_BR_T    = 17'h01840;
    localparam logic [16:0] V_EX_BR_N    = 17'h00840;
    localparam logic [16:0] V_EX_J       = 17'h01800;
    localparam logic [16:0] V_EX_LUI     = 17'h00200;
    localparam logic [16:0] V_EX_AUIPC   = 17'h00600;
    localparam logic [16:0] V_MEM_LD     = 17'h14000;
    localparam logic [16:0] V_MEM_ST     = 17'h0C000;
    localparam logic [16:0] V_WB_ALU     = 17'h00020;
    localparam logic [16:0] V_WB_LD      = 17'h00028;
    localparam logic [16:0] V_WB_J       = 17'h00030;
    localparam logic [16:0] V_TRAP_ILL   = 17'h00005;
    localparam logic [16:0] V_TRAP_TO    = 17'h00006;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_nj = 1'b0;
    logic       nj_en = 1'b0;
    logic       mem_ready = 1'b0;
    logic       br_taken = 1'b0;
    logic [6:0] opcode = 7'd0;

    logic             m_mem_read, m_mem_write, m_iord, m_ir_write, m_pc_write, m_pc_src;
    logic             m_alu_src_a, m_reg_write, m_trap;
    logic [1:0]       m_alu_src_b, m_alu_op, m_mem_to_reg, m_trap_cause;
    logic [CNT_W-1:0] m_instret;
    logic             n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write, n_pc_src;
    logic             n_alu_src_a, n_reg_write, n_trap;
    logic [1:0]       n_alu_src_b, n_alu_op, n_mem_to_reg, n_trap_cause;
    logic [31:0]      n_instret;
    logic [16:0]      m_vec, n_vec;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (CNT_W),
        .EN_JUMP     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .br_taken   (br_taken),
        .mem_read   (m_mem_read),
        .mem_write  (m_mem_write),
        .iord       (m_iord),
        .ir_write   (m_ir_write),
        .pc_write   (m_pc_write),
        .pc_src     (m_pc_src),
        .alu_src_a  (m_alu_src_a),
        .alu_src_b  (m_alu_src_b),
        .alu_op     (m_alu_op),
        .reg_write  (m_reg_write),
        .mem_to_reg (m_mem_to_reg),
        .trap       (m_trap),
        .trap_cause (m_trap_cause),
        .instret    (m_instret)
    );

    riscv_multicycle_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (32),
        .EN_JUMP     (0)
    ) dut_nj (
        .clk        (clk),
        .rst_n      (rst_n_nj),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .br_taken   (br_taken),
        .mem_read   (n_mem_read),
        .mem_write  (n_mem_write),
        .iord       (n_iord),
        .ir_write   (n_ir_write),
        .pc_write   (n_pc_write),
        .pc_src     (n_pc_src),
        .alu_src_a  (n_alu_src_a),
        .alu_src_b  (n_alu_src_b),
        .alu_op     (n_alu_op),
        .reg_write  (n_reg_write),
        .mem_to_reg (n_mem_to_reg),
        .trap       (n_trap),
        .trap_cause (n_trap_cause),
        .instret    (n_instret)
    );

    assign m_vec = {m_mem_read, m_mem_write, m_iord, m_ir_write, m_pc_write, m_pc_src,
                    m_alu_src_a, m_alu_src_b, m_alu_op, m_reg_write, m_mem_to_reg,
                    m_trap, m_trap_cause};
    assign n_vec = {n_mem_read, n_mem_write, n_iord, n_ir_write, n_pc_write, n_pc_src,
                    n_alu_src_a, n_alu_src_b, n_alu_op, n_reg_write, n_mem_to_reg,
                    n_trap, n_trap_cause};

    typedef struct {
        int          cyc;
        int          inst;
        string       nm;
        logic [16:0] vec;
        int          ir;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   exp_ir = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due this cycle against the DUT.
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] av;
        int          air;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.inst == 0) begin
                av  = m_vec;
                air = int'(m_instret);
            end else begin
                av  = n_vec;
                air = int'(n_instret);
            end
            checks++;
            if (e.cyc != cyc || av !== e.vec || air != e.ir) begin
                errors++;
                $display("FAIL %s (dut%0d cyc %0d/%0d): got outputs=%05h instret=%0d, expected outputs=%05h instret=%0d",
                         e.nm, e.inst, cyc, e.cyc, av, air, e.vec, e.ir);
            end else begin
                $display("ok   %s (dut%0d cyc %0d): outputs=%05h instret=%0d",
                         e.nm, e.inst, cyc, av, air);
            end
        end
    end

    // One clock of stimulus for the main DUT plus its expected outputs.
    task automatic drive(input logic rn, input logic rdy, input logic [6:0] op,
                         input logic br, input logic [16:0] ev, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        rst_n_nj  = rn & nj_en;
        mem_ready = rdy;
        opcode    = op;
        br_taken  = br;
        e.cyc  = cyc;
        e.inst = 0;
        e.nm   = nm;
        e.vec  = ev;
        e.ir   = rn ? (exp_ir % (1 << CNT_W)) : 0;
        sb_q.push_back(e);
    endtask

    // Expectation for the EN_JUMP=0 instance in the cycle just driven.
    task automatic expect_nj(input logic [16:0] ev, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.inst = 1;
        e.nm   = nm;
        e.vec  = ev;
        e.ir   = 0;
        sb_q.push_back(e);
    endtask

    // Full instruction with mem_ready=1: FETCH, DECODE, then n tail cycles.
    task automatic run_instr(input logic [6:0] op, input logic br, input int n,
                             input logic [16:0] t0, input logic [16:0] t1,
                             input logic [16:0] t2, input string nm);
        logic [16:0] t[3];
        t = '{t0, t1, t2};
        drive(1'b1, 1'b1, op, br, V_FETCH_RDY, {nm, ".fetch"});
        drive(1'b1, 1'b1, op, br, V_DECODE, {nm, ".decode"});
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, op, br, t[i], $sformatf("%s.s%0d", nm, i + 3));
        end
        exp_ir++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 7'd0, 1'b0, V_ZERO, "reset");
        exp_ir = 0;
        drive(1'b1, 1'b0, 7'd0, 1'b0, V_FETCH_WAIT, "release_fetch");
    endtask

    initial begin
        // Reset held 3 cycles, release, then a stalled fetch.
        do_reset(3);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 7'd0, 1'b0, V_FETCH_WAIT, "fetch_stall");

        // Mixed sequence: CPIs 4, 5, 4, 3, 3, 4.
        run_instr(OP_R,      1'b0, 2, V_EX_R,    V_WB_ALU,  V_ZERO,  "R");
        run_instr(OP_LOAD,   1'b0, 3, V_EX_LS,   V_MEM_LD,  V_WB_LD, "LOAD");
        run_instr(OP_STORE,  1'b0, 2, V_EX_LS,   V_MEM_ST,  V_ZERO,  "STORE");
        run_instr(OP_BRANCH, 1'b1, 1, V_EX_BR_T, V_ZERO,    V_ZERO,  "BR_taken");
        run_instr(OP_BRANCH, 1'b0, 1, V_EX_BR_N, V_ZERO,    V_ZERO,  "BR_not");
        run_instr(OP_JAL,    1'b0, 2, V_EX_J,    V_WB_J,    V_ZERO,  "JAL");
        // Remaining classes; the first fetch below also checks instret=6.
        run_instr(OP_I,      1'b0, 2, V_EX_I,    V_WB_ALU,  V_ZERO,  "IALU");
        run_instr(OP_JALR,   1'b0, 2, V_EX_J,    V_WB_J,    V_ZERO,  "JALR");
        run_instr(OP_LUI,    1'b0, 2, V_EX_LUI,  V_WB_ALU,  V_ZERO,  "LUI");
        run_instr(OP_AUIPC,  1'b0, 2, V_EX_AUIPC, V_WB_ALU, V_ZERO,  "AUIPC");

        // Load whose mem_ready arrives exactly on the 15th counted wait.
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_FETCH_RDY, "ld15.fetch");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_DECODE, "ld15.decode");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_EX_LS, "ld15.exec");
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, OP_LOAD, 1'b0, V_MEM_LD, "ld15.mem_wait");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_MEM_LD, "ld15.mem_ready_at_limit");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_WB_LD, "ld15.wb");
        exp_ir++;

        // Illegal opcode: trap after DECODE, sticky, instret unchanged.
        drive(1'b1, 1'b1, 7'd0, 1'b0, V_FETCH_RDY, "ill.fetch");
        drive(1'b1, 1'b1, 7'd0, 1'b0, V_DECODE, "ill.decode");
        drive(1'b1, 1'b1, 7'd0, 1'b0, V_TRAP_ILL, "ill.trap");
        drive(1'b1, 1'b0, OP_R, 1'b0, V_TRAP_ILL, "ill.trap_hold");
        drive(1'b1, 1'b1, OP_R, 1'b1, V_TRAP_ILL, "ill.trap_hold");
        do_reset(2);

        // 17 branches on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            run_instr(OP_BRANCH, i[0], 1, i[0] ? V_EX_BR_T : V_EX_BR_N, V_ZERO, V_ZERO, "wrap_br");
        end
        drive(1'b1, 1'b0, 7'd0, 1'b0, V_FETCH_WAIT, "wrap_check");

        // Reset in the middle of a stalled store: abort and restart in FETCH.
        drive(1'b1, 1'b1, OP_STORE, 1'b0, V_FETCH_RDY, "st_abort.fetch");
        drive(1'b1, 1'b1, OP_STORE, 1'b0, V_DECODE, "st_abort.decode");
        drive(1'b1, 1'b0, OP_STORE, 1'b0, V_EX_LS, "st_abort.exec");
        drive(1'b1, 1'b0, OP_STORE, 1'b0, V_MEM_ST, "st_abort.mem_wait");
        drive(1'b1, 1'b0, OP_STORE, 1'b0, V_MEM_ST, "st_abort.mem_wait");
        do_reset(1);

        // Load starved of mem_ready: timeout trap after 15 counted waits.
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_FETCH_RDY, "ldto.fetch");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_DECODE, "ldto.decode");
        drive(1'b1, 1'b0, OP_LOAD, 1'b0, V_EX_LS, "ldto.exec");
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, OP_LOAD, 1'b0, V_MEM_LD, "ldto.mem_wait");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_TRAP_TO, "ldto.trap");
        drive(1'b1, 1'b1, OP_LOAD, 1'b0, V_TRAP_TO, "ldto.trap_hold");

        // LUI on both instances: EN_JUMP=1 writes back, EN_JUMP=0 traps.
        nj_en = 1'b1;
        drive(1'b0, 1'b0, 7'd0, 1'b0, V_ZERO, "reset");
        exp_ir = 0;
        drive(1'b1, 1'b0, OP_LUI, 1'b0, V_FETCH_WAIT, "lui.release");
        expect_nj(V_FETCH_WAIT, "lui_nj.release");
        drive(1'b1, 1'b1, OP_LUI, 1'b0, V_FETCH_RDY, "lui.fetch");
        expect_nj(V_FETCH_RDY, "lui_nj.fetch");
        drive(1'b1, 1'b1, OP_LUI, 1'b0, V_DECODE, "lui.decode");
        expect_nj(V_DECODE, "lui_nj.decode");
        drive(1'b1, 1'b1, OP_LUI, 1'b0, V_EX_LUI, "lui.exec");
        expect_nj(V_TRAP_ILL, "lui_nj.trap");
        drive(1'b1, 1'b1, OP_LUI, 1'b0, V_WB_ALU, "lui.wb");
        expect_nj(V_TRAP_ILL, "lui_nj.trap_hold");
        exp_ir++;
        drive(1'b1, 1'b0, 7'd0, 1'b0, V_FETCH_WAIT, "lui.retired");
        expect_nj(V_TRAP_ILL, "lui_nj.trap_hold");

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
